dm_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-ported data memory (`dm`) between the CPU load/store port (m0) and a second master such as a loader or debug port (m1). It registers each granted request, drives the memory for exactly one cycle, captures read data, and returns a one-cycle acknowledge to the winning master. It sits between the pipeline's MEM stage and the `dm` instance. The memory keeps its combinational read, synchronous write and `$display` write trace.

---
 rtl/dm_arbiter.sv | 137 +++++++++++++
 tb/tb_dm_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin sharing of the single-ported data memory
// between the CPU load/store port (m0) and a second master (m1).
module dm_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [31:0]   m0_pc,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [31:0]   m1_pc,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_A,
    output logic [DW-1:0] mem_WD,
    output logic          mem_WE,
    output logic [31:0]   mem_PC,
    input  logic [DW-1:0] mem_RD
);

    typedef enum logic {
        IDLE,
        SERVE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          gnt;
    logic          last;
    logic          take;
    logic          pick;
    logic          elig0;
    logic          elig1;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [31:0]   cmd_pc;

    // A pending ack masks its master so a held request is not served twice.
    assign elig0 = m0_req & ~m0_ack;
    assign elig1 = m1_req & ~m1_ack;

    // The memory port always shows the last command; only WE depends on state.
    assign mem_A  = cmd_addr;
    assign mem_WD = cmd_wdata;
    assign mem_PC = cmd_pc;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Arbitration, next state and write-enable decode.
    always_comb begin
        state_nx = state;
        take     = 1'b0;
        pick     = 1'b0;
        mem_WE   = 1'b0;
        unique case (state)
            IDLE: begin
                if (elig0 && elig1) begin
                    take = 1'b1;
                    pick = ~last;
                end else if (elig0) begin
                    take = 1'b1;
                    pick = 1'b0;
                end else if (elig1) begin
                    take = 1'b1;
                    pick = 1'b1;
                end
                if (take) begin
                    state_nx = SERVE;
                end
            end
            SERVE: begin
                mem_WE   = cmd_we;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latch the winner and its command at grant time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt       <= 1'b0;
            last      <= 1'b1;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_pc    <= '0;
        end else if (take) begin
            gnt       <= pick;
            last      <= pick;
            cmd_we    <= pick ? m1_we    : m0_we;
            cmd_addr  <= pick ? m1_addr  : m0_addr;
            cmd_wdata <= pick ? m1_wdata : m0_wdata;
            cmd_pc    <= pick ? m1_pc    : m0_pc;
        end
    end

    // Capture read data and pulse the winner's ack as SERVE ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            if (state == SERVE) begin
                if (gnt) begin
                    m1_ack   <= 1'b1;
                    m1_rdata <= mem_RD;
                end else begin
                    m0_ack   <= 1'b1;
                    m0_rdata <= mem_RD;
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter with a word memory
// model standing in for dm.
module tb_dm_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m0_pc;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [31:0] m1_pc;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_PC;
    logic [31:0] mem_RD;

    typedef struct {
        logic        m;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [0:255] = '{default: 32'h0};
    int          wcount [0:255] = '{default: 0};
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          we_cycles = 0;

    dm_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_pc(m0_pc),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_pc(m1_pc),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE),
        .mem_PC(mem_PC), .mem_RD(mem_RD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // dm model: combinational read, synchronous write with trace
    assign mem_RD = mem[mem_A[9:2]];

    always @(posedge clk) begin
        if (mem_WE) begin
            mem[mem_A[9:2]] <= mem_WD;
            wcount[mem_A[9:2]] <= wcount[mem_A[9:2]] + 1;
            $display("@%h: *%h <= %h", mem_PC, mem_A, mem_WD);
        end
    end

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_pc = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_pc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        tests++;
        if ({m0_ack, m1_ack, mem_WE} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctl: got %b want 000", {m0_ack, m1_ack, mem_WE});
        end
        tests++;
        if ({mem_A, mem_WD, mem_PC} !== 96'h0) begin
            fails++;
            $display("FAIL reset_mem: got %h %h %h want 0", mem_A, mem_WD, mem_PC);
        end
        tests++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin
            fails++;
            $display("FAIL reset_rdata: got %h %h want 0", m0_rdata, m1_rdata);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_m0_write();
        int k;
        int w0;
        @(negedge clk);
        w0 = we_cycles;
        k = cyc;
        m0_req = 1; m0_we = 1; m0_addr = 32'h10;
        m0_wdata = 32'hDEADBEEF; m0_pc = 32'h3000;
        exp_q.push_back('{1'b0, mem[4], k + 2});
        @(negedge clk);
        tests++;
        if ({mem_WE, mem_A, mem_WD, mem_PC} !== {1'b1, 32'h10, 32'hDEADBEEF, 32'h3000}) begin
            fails++;
            $display("FAIL wr_serve: got we=%b a=%h d=%h pc=%h want 1 10 deadbeef 3000",
                     mem_WE, mem_A, mem_WD, mem_PC);
        end
        repeat (6) begin
            @(negedge clk);
            if (m0_ack) m0_req = 0;
        end
        m0_req = 0;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL wr_ack: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
        tests++;
        if (we_cycles - w0 != 1) begin
            fails++;
            $display("FAIL wr_we_width: got %0d want 1", we_cycles - w0);
        end
        tests++;
        if (mem[4] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL wr_commit: got %h want deadbeef", mem[4]);
        end
        tests++;
        if ({mem_WE, mem_A} !== {1'b0, 32'h10}) begin
            fails++;
            $display("FAIL wr_idle_hold: got we=%b a=%h want 0 10", mem_WE, mem_A);
        end
    endtask

    task automatic test_m1_read();
        int k;
        int w0;
        @(negedge clk);
        w0 = we_cycles;
        k = cyc;
        m1_req = 1; m1_we = 0; m1_addr = 32'h10; m1_pc = 32'h4000;
        exp_q.push_back('{1'b1, mem[4], k + 2});
        repeat (6) begin
            @(negedge clk);
            if (m1_ack) m1_req = 0;
        end
        m1_req = 0;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL rd_ack: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
        tests++;
        if (we_cycles != w0) begin
            fails++;
            $display("FAIL rd_no_we: got %0d we cycles want 0", we_cycles - w0);
        end
        tests++;
        if (m1_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL rd_hold: got %h want deadbeef", m1_rdata);
        end
    endtask

    task automatic test_contention();
        int k;
        int w0;
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        w0 = we_cycles;
        k = cyc;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_pc = 32'h3100;
        m1_req = 1; m1_we = 0; m1_addr = 32'h14; m1_pc = 32'h4100;
        exp_q.push_back('{1'b0, mem[4], k + 2});
        exp_q.push_back('{1'b1, mem[5], k + 4});
        exp_q.push_back('{1'b0, mem[4], k + 6});
        exp_q.push_back('{1'b1, mem[5], k + 8});
        repeat (8) @(negedge clk);
        m0_req = 0;
        m1_req = 0;
        repeat (4) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL rr_acks: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
        tests++;
        if (we_cycles != w0) begin
            fails++;
            $display("FAIL rr_no_we: got %0d want 0", we_cycles - w0);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int acks;
        int w8;
        int w9;
        @(negedge clk);
        w8 = wcount[8];
        w9 = wcount[9];
        acks = 0;
        k = cyc;
        m0_req = 1; m0_we = 1; m0_addr = 32'h20;
        m0_wdata = 32'h1111_1111; m0_pc = 32'h3004;
        exp_q.push_back('{1'b0, mem[8], k + 2});
        exp_q.push_back('{1'b0, mem[9], k + 5});
        repeat (10) begin
            @(negedge clk);
            if (m0_ack) begin
                acks++;
                if (acks == 1) begin
                    m0_addr = 32'h24;
                    m0_wdata = 32'h2222_2222;
                    m0_pc = 32'h3008;
                end else begin
                    m0_req = 0;
                end
            end
        end
        m0_req = 0;
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_acks: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
        tests++;
        if (wcount[8] - w8 != 1 || wcount[9] - w9 != 1) begin
            fails++;
            $display("FAIL b2b_once: got %0d %0d want 1 1", wcount[8] - w8, wcount[9] - w9);
        end
        tests++;
        if ({mem[8], mem[9]} !== {32'h1111_1111, 32'h2222_2222}) begin
            fails++;
            $display("FAIL b2b_data: got %h %h want 11111111 22222222", mem[8], mem[9]);
        end
    endtask

    task automatic test_reset_abort();
        int k;
        @(negedge clk);
        k = cyc;
        m1_req = 1; m1_we = 1; m1_addr = 32'h40;
        m1_wdata = 32'hA5A5_A5A5; m1_pc = 32'h5000;
        exp_q.push_back('{1'b1, mem[16], k + 2});
        repeat (5) begin
            @(negedge clk);
            if (m1_ack) m1_req = 0;
        end
        m1_req = 0;
        tests++;
        if (exp_q.size() != 0 || mem[16] !== 32'hA5A5_A5A5) begin
            fails++;
            $display("FAIL abort_setup: got pend=%0d mem=%h want 0 a5a5a5a5",
                     exp_q.size(), mem[16]);
            exp_q.delete();
        end
        @(negedge clk);
        m1_req = 1; m1_we = 1; m1_addr = 32'h40;
        m1_wdata = 32'h1234_5678; m1_pc = 32'h5004;
        @(negedge clk);
        tests++;
        if (mem_WE !== 1'b1) begin
            fails++;
            $display("FAIL abort_serve: got we=%b want 1", mem_WE);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (mem_WE !== 1'b0) begin
            fails++;
            $display("FAIL abort_we_drop: got %b want 0", mem_WE);
        end
        m1_req = 0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (mem[16] !== 32'hA5A5_A5A5) begin
            fails++;
            $display("FAIL abort_keep: got %h want a5a5a5a5", mem[16]);
        end
        tests++;
        if ({m0_ack, m1_ack, mem_WE, mem_A, mem_WD, mem_PC, m0_rdata, m1_rdata} !== 163'h0) begin
            fails++;
            $display("FAIL abort_zero: got a=%h d=%h pc=%h r0=%h r1=%h ack=%b%b",
                     mem_A, mem_WD, mem_PC, m0_rdata, m1_rdata, m0_ack, m1_ack);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        fork
            forever begin
                exp_t e;
                logic        gm;
                logic [31:0] gr;
                @(negedge clk);
                if (mem_WE) we_cycles++;
                if (m0_ack || m1_ack) begin
                    tests++;
                    gm = m1_ack;
                    gr = m1_ack ? m1_rdata : m0_rdata;
                    if (m0_ack && m1_ack) begin
                        fails++;
                        $display("FAIL dual_ack: got both acks at cycle %0d want one", cyc);
                    end else if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL extra_ack: got m%0d ack at cycle %0d want none", gm, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (gm !== e.m || gr !== e.rdata || cyc != e.cyc) begin
                            fails++;
                            $display("FAIL ack: got m%0d rd=%h cyc=%0d want m%0d rd=%h cyc=%0d",
                                     gm, gr, cyc, e.m, e.rdata, e.cyc);
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_m0_write();
        test_m1_read();
        test_contention();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
